// File: rtl/sipo_frame_ctrl_if.sv
// Handshake and serial-link bundle for the SIPO frame controller.
// SIPO_FRAME_PARITY_EN adds the parity_err output to the bundle.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 6
);
    logic             i_enable;
    logic             i_serial_in;
    logic             i_frame_start;
    logic             i_out_ready;
    logic             i_clear_overrun;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_overrun;
    logic [CNT_W-1:0] o_bit_cnt;
`ifdef SIPO_FRAME_PARITY_EN
    logic             o_parity_err;

    // Producer/consumer side: drives the link and ready, observes the word path
    modport master (
        output i_enable, i_serial_in, i_frame_start, i_out_ready, i_clear_overrun,
        input  o_out_data, o_out_valid, o_busy, o_overrun, o_bit_cnt, o_parity_err
    );

    // Controller side
    modport slave (
        input  i_enable, i_serial_in, i_frame_start, i_out_ready, i_clear_overrun,
        output o_out_data, o_out_valid, o_busy, o_overrun, o_bit_cnt, o_parity_err
    );
`else
    // Producer/consumer side: drives the link and ready, observes the word path
    modport master (
        output i_enable, i_serial_in, i_frame_start, i_out_ready, i_clear_overrun,
        input  o_out_data, o_out_valid, o_busy, o_overrun, o_bit_cnt
    );

    // Controller side
    modport slave (
        input  i_enable, i_serial_in, i_frame_start, i_out_ready, i_clear_overrun,
        output o_out_data, o_out_valid, o_busy, o_overrun, o_bit_cnt
    );
`endif
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame-level serial-to-parallel controller: detects frame start, shifts in
// WIDTH bits, and hands each word to a one-entry valid/ready holding register.
// A completed frame that finds the holding register full is dropped and
// raises the sticky overrun flag.
// Optional build macro SIPO_FRAME_PARITY_EN: appends an even-parity bit to
// every frame, adds a PARITY state and a one-cycle parity_err pulse.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 6
) (
    input logic              clk,
    input logic              reset,
    sipo_frame_ctrl_if.slave bus
);

`ifdef SIPO_FRAME_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_shiftReg;
    logic [WIDTH-1:0] w_shiftNext;
    logic [CNT_W-1:0] r_bitCnt;
    logic [CNT_W-1:0] w_bitCntNext;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_startWord;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] r_outData;
    logic             r_outValid;
    logic             r_overrun;
`ifdef SIPO_FRAME_PARITY_EN
    logic             w_parityOk;
    logic             w_parityErr;
    logic             r_parityErr;
`endif

    // Candidate shift-register values: continue the frame, or start a fresh one from a cleared register
    always_comb begin
        w_shifted   = r_shiftReg;
        w_startWord = '0;
        if (MSB_FIRST != 0) begin
            w_shifted   = {r_shiftReg[WIDTH-2:0], bus.i_serial_in};
            w_startWord = {{(WIDTH-1){1'b0}}, bus.i_serial_in};
        end else begin
            w_shifted   = {bus.i_serial_in, r_shiftReg[WIDTH-1:1]};
            w_startWord = {bus.i_serial_in, {(WIDTH-1){1'b0}}};
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    // Even parity: data bits plus the incoming parity bit must XOR to zero
    always_comb begin
        w_parityOk = ~(^{r_shiftReg, bus.i_serial_in});
    end
`endif

    // State register with the shift path; partial frames vanish on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_shiftReg <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
        end
    end

    // Next-state logic: only enable cycles move the frame; frame_start always restarts at bit 0
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shiftReg;
        w_bitCntNext = r_bitCnt;
        w_complete   = 1'b0;
        w_word       = w_shifted;
`ifdef SIPO_FRAME_PARITY_EN
        w_parityErr  = 1'b0;
`endif
        if (bus.i_enable) begin
            if (bus.i_frame_start) begin
                w_stateNext  = SHIFT;
                w_shiftNext  = w_startWord;
                w_bitCntNext = CNT_W'(1);
            end else begin
                case (r_state)
                    SHIFT: begin
                        w_shiftNext = w_shifted;
                        if (r_bitCnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_PARITY_EN
                            w_stateNext  = PARITY;
                            w_bitCntNext = CNT_W'(WIDTH);
`else
                            w_stateNext  = IDLE;
                            w_bitCntNext = '0;
                            w_complete   = 1'b1;
                            w_word       = w_shifted;
`endif
                        end else begin
                            w_bitCntNext = r_bitCnt + CNT_W'(1);
                        end
                    end
`ifdef SIPO_FRAME_PARITY_EN
                    PARITY: begin
                        w_stateNext  = IDLE;
                        w_bitCntNext = '0;
                        w_word       = r_shiftReg;
                        if (w_parityOk) begin
                            w_complete  = 1'b1;
                        end else begin
                            w_parityErr = 1'b1;
                        end
                    end
`endif
                    default: begin
                        w_stateNext = IDLE;
                    end
                endcase
            end
        end
    end

    // A finished word is taken if the holder is empty or being emptied this same cycle
    always_comb begin
        w_drop = w_complete & r_outValid & ~bus.i_out_ready;
        w_load = w_complete & ~w_drop;
    end

    // One-entry holding register; a load during a transfer keeps valid high with no bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_outData  <= w_word;
            r_outValid <= 1'b1;
        end else if (r_outValid && bus.i_out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.i_clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    // Parity error is a single-cycle pulse following the bad parity bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parityErr <= 1'b0;
        end else begin
            r_parityErr <= w_parityErr;
        end
    end

    assign bus.o_parity_err = r_parityErr;
    assign bus.o_busy       = (r_state == SHIFT) || (r_state == PARITY);
`else
    assign bus.o_busy       = (r_state == SHIFT);
`endif

    assign bus.o_out_data  = r_outData;
    assign bus.o_out_valid = r_outValid;
    assign bus.o_overrun   = r_overrun;
    assign bus.o_bit_cnt   = r_bitCnt;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl (WIDTH=4, MSB_FIRST=1).
// Words are pushed to a scoreboard queue when a frame that should be
// delivered is sent, and popped by a monitor on every accepted transfer.
// Build with SIPO_FRAME_PARITY_EN to exercise the parity variant.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 6;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [WIDTH-1:0] expQ[$];

    sipo_frame_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sipo_frame_ctrl #(
        .WIDTH(WIDTH),
        .MSB_FIRST(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: every accepted word must match the oldest expected word
    always @(negedge clk) begin
        logic [WIDTH-1:0] expWord;
        if (!reset && bus.o_out_valid === 1'b1 && bus.i_out_ready === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_pop: got %b but no word expected", bus.o_out_data);
            end else begin
                expWord = expQ.pop_front();
                if (bus.o_out_data !== expWord) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_data: got %b expected %b", bus.o_out_data, expWord);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bit event; returns 1 time unit after the capturing edge
    task automatic applyStimulus(input logic b, input logic fs);
        bus.i_enable      = 1'b1;
        bus.i_serial_in   = b;
        bus.i_frame_start = fs;
        @(posedge clk);
        #1;
        bus.i_enable      = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_serial_in   = 1'b0;
    endtask

    // Non-event cycle with frame_start and data toggling, all of which must be ignored
    task automatic idleCycle();
        bus.i_enable      = 1'b0;
        bus.i_frame_start = 1'b1;
        bus.i_serial_in   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        bus.i_frame_start = 1'b0;
        bus.i_serial_in   = 1'b0;
    endtask

    // Full frame, MSB first, with parity appended in the parity build
    task automatic sendFrame(input logic [WIDTH-1:0] w, input bit readyAtLast);
        for (int i = 0; i < WIDTH; i++) begin
`ifndef SIPO_FRAME_PARITY_EN
            if (readyAtLast && i == WIDTH - 1) bus.i_out_ready = 1'b1;
`endif
            applyStimulus(w[WIDTH-1-i], (i == 0));
        end
`ifdef SIPO_FRAME_PARITY_EN
        if (readyAtLast) bus.i_out_ready = 1'b1;
        applyStimulus(^w, 1'b0);
`endif
    endtask

    // Raise ready until the holder empties, bounded
    task automatic drain();
        int n;
        n = 0;
        bus.i_out_ready = 1'b1;
        while (bus.o_out_valid === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.i_out_ready = 1'b0;
        checks++;
        if (bus.o_out_valid !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: out_valid=%b pending=%0d required 0/0", bus.o_out_valid, expQ.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.o_out_data !== 4'b0 || bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
            bus.o_overrun !== 1'b0 || bus.o_bit_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: data=%b valid=%b busy=%b ovr=%b cnt=%0d required all 0",
                     bus.o_out_data, bus.o_out_valid, bus.o_busy, bus.o_overrun, bus.o_bit_cnt);
        end
`ifdef SIPO_FRAME_PARITY_EN
        checks++;
        if (bus.o_parity_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_parity_err: got %b required 0", bus.o_parity_err);
        end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        bus.i_out_ready = 1'b0;
        expQ.push_back(4'b1011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bits[3-i], (i == 0));
            checks++;
            if (bus.o_bit_cnt !== 6'(i + 1) || bus.o_busy !== 1'b1 || bus.o_out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_bit%0d: cnt=%0d busy=%b valid=%b required %0d/1/0",
                         i + 1, bus.o_bit_cnt, bus.o_busy, bus.o_out_valid, i + 1);
            end
        end
        applyStimulus(bits[0], 1'b0);
`ifdef SIPO_FRAME_PARITY_EN
        checks++;
        if (bus.o_bit_cnt !== 6'd4 || bus.o_busy !== 1'b1 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_parity_wait: cnt=%0d busy=%b valid=%b required 4/1/0",
                     bus.o_bit_cnt, bus.o_busy, bus.o_out_valid);
        end
        applyStimulus(1'b1, 1'b0);
`endif
        checks++;
        if (bus.o_bit_cnt !== 6'd0 || bus.o_busy !== 1'b0 || bus.o_out_valid !== 1'b1 ||
            bus.o_out_data !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL basic_done: cnt=%0d busy=%b valid=%b data=%b required 0/0/1/1011",
                     bus.o_bit_cnt, bus.o_busy, bus.o_out_valid, bus.o_out_data);
        end
        drain();
    endtask

    task automatic test_enable_gap();
        logic [3:0] bits;
        bits = 4'b1011;
        expQ.push_back(4'b1011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bits[3-i], (i == 0));
            idleCycle();
            checks++;
            if (bus.o_bit_cnt !== 6'(i + 1)) begin
                errors++;
                $display("[TB] FAIL gap_hold%0d: cnt=%0d required %0d", i + 1, bus.o_bit_cnt, i + 1);
            end
        end
        applyStimulus(bits[0], 1'b0);
`ifdef SIPO_FRAME_PARITY_EN
        idleCycle();
        applyStimulus(1'b1, 1'b0);
`endif
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL gap_word: valid=%b data=%b required 1/1011", bus.o_out_valid, bus.o_out_data);
        end
        drain();
    endtask

    task automatic test_overrun();
        bus.i_out_ready = 1'b0;
        expQ.push_back(4'b1011);
        sendFrame(4'b1011, 1'b0);
        sendFrame(4'b0110, 1'b0);
        checks++;
        if (bus.o_out_data !== 4'b1011 || bus.o_overrun !== 1'b1 || bus.o_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set: data=%b ovr=%b valid=%b required 1011/1/1",
                     bus.o_out_data, bus.o_overrun, bus.o_out_valid);
        end
        bus.i_clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clear_overrun = 1'b0;
        checks++;
        if (bus.o_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %b required 0", bus.o_overrun);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.i_out_ready = 1'b0;
        expQ.push_back(4'b1100);
        expQ.push_back(4'b0011);
        sendFrame(4'b1100, 1'b0);
        sendFrame(4'b0011, 1'b1);
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 4'b0011 || bus.o_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_handoff: valid=%b data=%b ovr=%b required 1/0011/0",
                     bus.o_out_valid, bus.o_out_data, bus.o_overrun);
        end
        drain();
    endtask

    task automatic test_abort_and_reset();
        bus.i_out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checks++;
        if (bus.o_bit_cnt !== 6'd2) begin
            errors++;
            $display("[TB] FAIL abort_partial: cnt=%0d required 2", bus.o_bit_cnt);
        end
        expQ.push_back(4'b0101);
        applyStimulus(1'b0, 1'b1);
        checks++;
        if (bus.o_bit_cnt !== 6'd1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_restart: cnt=%0d busy=%b required 1/1", bus.o_bit_cnt, bus.o_busy);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
`ifdef SIPO_FRAME_PARITY_EN
        applyStimulus(1'b0, 1'b0);
`endif
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 4'b0101 || bus.o_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_word: valid=%b data=%b ovr=%b required 1/0101/0",
                     bus.o_out_valid, bus.o_out_data, bus.o_overrun);
        end
        drain();

        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        #2;
        checks++;
        if (bus.o_out_data !== 4'b0 || bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
            bus.o_overrun !== 1'b0 || bus.o_bit_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: data=%b valid=%b busy=%b ovr=%b cnt=%0d required all 0",
                     bus.o_out_data, bus.o_out_valid, bus.o_busy, bus.o_overrun, bus.o_bit_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expQ.push_back(4'b1011);
        sendFrame(4'b1011, 1'b0);
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL post_reset_word: valid=%b data=%b required 1/1011",
                     bus.o_out_valid, bus.o_out_data);
        end
        drain();
    endtask

`ifdef SIPO_FRAME_PARITY_EN
    task automatic test_parity();
        bus.i_out_ready = 1'b0;
        expQ.push_back(4'b1011);
        sendFrame(4'b1011, 1'b0);
        checks++;
        if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== 4'b1011 || bus.o_parity_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_good: valid=%b data=%b perr=%b required 1/1011/0",
                     bus.o_out_valid, bus.o_out_data, bus.o_parity_err);
        end
        drain();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checks++;
        if (bus.o_parity_err !== 1'b1 || bus.o_out_valid !== 1'b0 || bus.o_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_bad: perr=%b valid=%b ovr=%b required 1/0/0",
                     bus.o_parity_err, bus.o_out_valid, bus.o_overrun);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_parity_err !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_pulse: perr=%b valid=%b required 0/0",
                     bus.o_parity_err, bus.o_out_valid);
        end
    endtask
`endif

    // Test sequence
    initial begin
        checks              = 0;
        errors              = 0;
        reset               = 1'b1;
        bus.i_enable        = 1'b0;
        bus.i_serial_in     = 1'b0;
        bus.i_frame_start   = 1'b0;
        bus.i_out_ready     = 1'b0;
        bus.i_clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] starting functional tests");
        test_basic();
        test_enable_gap();
        test_overrun();
        test_back_to_back();
        test_abort_and_reset();
`ifdef SIPO_FRAME_PARITY_EN
        test_parity();
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
